// File: rtl/branch_unit_if.sv
// Request/result bundle between the CPU control FSM, the branch resolver and the pc load port.
interface branch_unit_if;
  logic       START;
  logic [7:0] OPCODE;
  logic [7:0] OFFSET;
  logic [15:0] PC_IN;
  logic [3:0] FLAGS;
  logic       BUSY;
  logic       DONE;
  logic       TAKEN;
  logic       ILLEGAL;
  logic [7:0] LO;
  logic [7:0] HI;
  logic       WR;

  modport master (
    output START, OPCODE, OFFSET, PC_IN, FLAGS,
    input  BUSY, DONE, TAKEN, ILLEGAL, LO, HI, WR
  );

  modport slave (
    input  START, OPCODE, OFFSET, PC_IN, FLAGS,
    output BUSY, DONE, TAKEN, ILLEGAL, LO, HI, WR
  );
endinterface

// File: rtl/branch_unit.sv
// Relative-branch resolver: evaluates the condition against P and forms the
// 16-bit target with 6502-style page-cross timing, strobing the pc load port.
module branch_unit #(
  parameter int unsigned FLAG_N = 3,
  parameter int unsigned FLAG_V = 2,
  parameter int unsigned FLAG_Z = 1,
  parameter int unsigned FLAG_C = 0
) (
  input logic         CLK,
  input logic         R,
  branch_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_FIX, S_DONE} state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [7:0]  off_q;
  logic [7:0]  lo_q;
  logic [7:0]  hi_q;
  logic        busy_q;
  logic        done_q;
  logic        taken_q;
  logic        illegal_q;
  logic        wr_q;

  logic        legal_c;
  logic        flag_c;
  logic        cond_c;
  logic [8:0]  sum9_c;
  logic        cross_c;

  // Opcode decode and condition evaluation on the live request inputs.
  always_comb begin
    legal_c = (bus.OPCODE[4:0] == 5'b10000);
    flag_c  = 1'b0;
    case (bus.OPCODE[7:6])
      2'b00:   flag_c = bus.FLAGS[FLAG_N];
      2'b01:   flag_c = bus.FLAGS[FLAG_V];
      2'b10:   flag_c = bus.FLAGS[FLAG_C];
      default: flag_c = bus.FLAGS[FLAG_Z];
    endcase
    cond_c = legal_c && (flag_c == bus.OPCODE[5]);
  end

  // Low-byte add; a carry out disagreeing with the offset sign means the page changed.
  assign sum9_c  = {1'b0, pc_q[7:0]} + {1'b0, off_q};
  assign cross_c = sum9_c[8] ^ off_q[7];

  always_ff @(posedge CLK) begin
    if (R) begin
      state_q   <= S_IDLE;
      pc_q      <= 16'h0000;
      off_q     <= 8'h00;
      lo_q      <= 8'h00;
      hi_q      <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wr_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.START) begin
            pc_q      <= bus.PC_IN;
            off_q     <= bus.OFFSET;
            lo_q      <= bus.PC_IN[7:0];
            hi_q      <= bus.PC_IN[15:8];
            illegal_q <= !legal_c;
            taken_q   <= cond_c;
            busy_q    <= 1'b1;
            if (cond_c) begin
              state_q <= S_ADD;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_ADD: begin
          lo_q <= sum9_c[7:0];
          hi_q <= pc_q[15:8];
          if (cross_c) begin
            state_q <= S_FIX;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            wr_q    <= taken_q;
          end
        end
        S_FIX: begin
          hi_q    <= off_q[7] ? pc_q[15:8] - 8'd1 : pc_q[15:8] + 8'd1;
          state_q <= S_DONE;
          done_q  <= 1'b1;
          wr_q    <= taken_q;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.TAKEN   = taken_q;
  assign bus.ILLEGAL = illegal_q;
  assign bus.LO      = lo_q;
  assign bus.HI      = hi_q;
  assign bus.WR      = wr_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: decode, latency, page cross, wrap, busy and reset behaviour.
module tb_branch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  branch_unit_if bif ();

  branch_unit dut (
    .CLK (clk),
    .R   (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, flip FLAGS after the sampling edge, then check the DONE cycle and the one after.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [3:0] flg,
                        input logic [15:0] pc, input logic [7:0] off, input int exp_lat,
                        input logic exp_taken, input logic exp_ill, input logic [15:0] exp_tgt);
    int lat;
    bif.OPCODE = op;
    bif.FLAGS  = flg;
    bif.PC_IN  = pc;
    bif.OFFSET = off;
    bif.START  = 1'b1;
    step();
    bif.START = 1'b0;
    bif.FLAGS = ~flg;
    lat = 1;
    while (bif.DONE !== 1'b1 && lat < 8) begin
      chk({tag, "_wr_early"}, 32'(bif.WR), 32'd0);
      step();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_done"}, 32'(bif.DONE), 32'd1);
    chk({tag, "_busy"}, 32'(bif.BUSY), 32'd1);
    chk({tag, "_taken"}, 32'(bif.TAKEN), 32'(exp_taken));
    chk({tag, "_illegal"}, 32'(bif.ILLEGAL), 32'(exp_ill));
    chk({tag, "_wr"}, 32'(bif.WR), 32'(exp_taken));
    chk({tag, "_target"}, 32'({bif.HI, bif.LO}), 32'(exp_tgt));
    step();
    chk({tag, "_done_after"}, 32'(bif.DONE), 32'd0);
    chk({tag, "_wr_after"}, 32'(bif.WR), 32'd0);
    chk({tag, "_busy_after"}, 32'(bif.BUSY), 32'd0);
    chk({tag, "_hold"}, 32'({bif.HI, bif.LO}), 32'(exp_tgt));
    chk({tag, "_taken_hold"}, 32'(bif.TAKEN), 32'(exp_taken));
  endtask

  initial begin
    int lat;
    bif.START  = 1'b0;
    bif.OPCODE = 8'h00;
    bif.OFFSET = 8'h00;
    bif.PC_IN  = 16'h0000;
    bif.FLAGS  = 4'h0;
    step();
    step();
    chk("rst_busy", 32'(bif.BUSY), 32'd0);
    chk("rst_done", 32'(bif.DONE), 32'd0);
    chk("rst_taken", 32'(bif.TAKEN), 32'd0);
    chk("rst_illegal", 32'(bif.ILLEGAL), 32'd0);
    chk("rst_wr", 32'(bif.WR), 32'd0);
    chk("rst_target", 32'({bif.HI, bif.LO}), 32'h0000);
    rst = 1'b0;
    step();

    run_op("bne_same",  8'hD0, 4'b0000, 16'h1234, 8'h10, 2, 1'b1, 1'b0, 16'h1244);
    run_op("beq_nt",    8'hF0, 4'b0000, 16'h1234, 8'h10, 1, 1'b0, 1'b0, 16'h1234);
    run_op("bcs_fwd",   8'hB0, 4'b0001, 16'h12F0, 8'h20, 3, 1'b1, 1'b0, 16'h1310);
    run_op("bcs_bwd",   8'hB0, 4'b0001, 16'h1205, 8'hF0, 3, 1'b1, 1'b0, 16'h11F5);
    run_op("bmi_wrapf", 8'h30, 4'b1000, 16'hFFF0, 8'h20, 3, 1'b1, 1'b0, 16'h0010);
    run_op("bmi_wrapb", 8'h30, 4'b1000, 16'h0005, 8'h80, 3, 1'b1, 1'b0, 16'hFF85);
    run_op("illegal",   8'hA9, 4'b1111, 16'h4321, 8'h10, 1, 1'b0, 1'b1, 16'h4321);
    run_op("bcc_off0",  8'h90, 4'b0000, 16'h2000, 8'h00, 2, 1'b1, 1'b0, 16'h2000);
    run_op("bvs_back",  8'h70, 4'b0100, 16'h2050, 8'hFE, 2, 1'b1, 1'b0, 16'h204E);
    run_op("bpl_nt",    8'h10, 4'b1000, 16'h3456, 8'h05, 1, 1'b0, 1'b0, 16'h3456);

    // START held high through the whole busy window with different operands.
    bif.OPCODE = 8'hB0;
    bif.FLAGS  = 4'b0001;
    bif.PC_IN  = 16'h12F0;
    bif.OFFSET = 8'h20;
    bif.START  = 1'b1;
    step();
    bif.OPCODE = 8'hD0;
    bif.FLAGS  = 4'b0000;
    bif.PC_IN  = 16'h5555;
    bif.OFFSET = 8'h01;
    lat = 1;
    while (bif.DONE !== 1'b1 && lat < 8) begin
      step();
      lat++;
    end
    chk("busy_lat", 32'(lat), 32'd3);
    chk("busy_target", 32'({bif.HI, bif.LO}), 32'h1310);
    chk("busy_wr", 32'(bif.WR), 32'd1);
    step();
    bif.START = 1'b0;
    chk("busy_idle", 32'(bif.BUSY), 32'd0);
    chk("busy_done_low", 32'(bif.DONE), 32'd0);
    chk("busy_hold", 32'({bif.HI, bif.LO}), 32'h1310);
    step();
    chk("busy_noaccept", 32'(bif.BUSY), 32'd0);

    // Reset while in the page-fix state.
    bif.OPCODE = 8'hB0;
    bif.FLAGS  = 4'b0001;
    bif.PC_IN  = 16'h12F0;
    bif.OFFSET = 8'h20;
    bif.START  = 1'b1;
    step();
    bif.START = 1'b0;
    step();
    chk("mid_busy", 32'(bif.BUSY), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(bif.BUSY), 32'd0);
    chk("mid_rst_done", 32'(bif.DONE), 32'd0);
    chk("mid_rst_wr", 32'(bif.WR), 32'd0);
    chk("mid_rst_target", 32'({bif.HI, bif.LO}), 32'h0000);
    step();
    chk("mid_rst_wr2", 32'(bif.WR), 32'd0);
    run_op("post_rst", 8'hD0, 4'b0000, 16'h1234, 8'h10, 2, 1'b1, 1'b0, 16'h1244);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Relative-branch resolver; sits directly upstream of the program counter.
- Fed by the CPU control FSM once a branch opcode (x0 with odd high nibble) and its signed offset byte have been fetched.
- Tests the condition against the P flags and computes the 16-bit target with 6502-style page-cross timing.
- Drives the pc load interface (LO/HI/WR) for one cycle when the branch is taken.

Parameters:
- FLAG_N, 3, bit position of negative flag in FLAGS
- FLAG_V, 2, bit position of overflow flag in FLAGS
- FLAG_Z, 1, bit position of zero flag in FLAGS
- FLAG_C, 0, bit position of carry flag in FLAGS

Ports:
- CLK  input  1  clock; all state changes on rising edge
- R  input  1  reset, synchronous, active-high
- START  input  1  request pulse; OPCODE/OFFSET/PC_IN/FLAGS sampled on the same edge
- OPCODE  input  8  branch opcode
- OFFSET  input  8  signed two's-complement displacement
- PC_IN  input  16  address of the instruction following the branch
- FLAGS  input  4  current P register
- BUSY  output  1  high in every non-idle state
- DONE  output  1  one-cycle completion pulse
- TAKEN  output  1  condition result; valid while DONE=1
- ILLEGAL  output  1  opcode not a branch; valid while DONE=1
- LO  output  8  target low byte to pc
- HI  output  8  target high byte to pc
- WR  output  1  pc load strobe; equals DONE && TAKEN

Behaviour:
- Reset:
  - On any edge with R=1, state goes to S_IDLE; takes priority over every other input.
  - BUSY, DONE, TAKEN, ILLEGAL, WR = 0; LO = 0x00, HI = 0x00.
  - Reset mid-operation aborts with no WR pulse.
- States: S_IDLE, S_ADD, S_FIX, S_DONE; all outputs decoded from registers (no combinational path from inputs).
- Decode:
  - Legal iff OPCODE[4:0] == 5'b10000.
  - OPCODE[7:6] selects the flag: 00 N, 01 V, 10 C, 11 Z.
  - Taken iff selected flag == OPCODE[5].
  - Examples: 0xD0 BNE (Z=0), 0xF0 BEQ (Z=1), 0x90 BCC (C=0), 0x30 BMI (N=1).
- S_IDLE with START=1:
  - Latch PC_IN, OFFSET, and the condition evaluated from FLAGS at this edge.
  - Illegal opcode: ILLEGAL=1, TAKEN=0, go to S_DONE.
  - Legal, not taken: TAKEN=0, go to S_DONE.
  - Legal, taken: go to S_ADD.
- S_ADD:
  - sum9 = {0,PC[7:0]} + {0,OFFSET}; LO <= sum9[7:0]; HI <= PC[15:8].
  - Page cross = sum9[8] XOR OFFSET[7].
  - No cross: go to S_DONE. Cross: go to S_FIX.
- S_FIX:
  - HI <= PC[15:8] + 1 if OFFSET[7]=0, else PC[15:8] - 1; modulo 256.
  - So 0xFFxx wraps forward to 0x00xx and 0x00xx wraps back to 0xFFxx.
  - Go to S_DONE.
- S_DONE:
  - DONE=1, WR=TAKEN, BUSY=1; next state S_IDLE.
  - TAKEN/ILLEGAL/LO/HI hold their values until the next accepted START or reset.
- Latency, counted as cycles from the START sampling edge to the cycle with DONE=1:
  - Not taken or illegal: 1.
  - Taken, same page: 2.
  - Taken, page cross: 3.
- Busy rules:
  - START while BUSY=1 (including the S_DONE cycle) is ignored; the latched operands are unchanged.
  - A new START is accepted in the cycle after DONE.
- Flag and offset rules:
  - FLAGS changes after the sampling edge do not affect the result.
  - OFFSET 0x00 taken gives target = PC_IN, 2 cycles.
  - OFFSET 0x80 is -128.
- When TAKEN=0, LO/HI hold PC_IN and WR stays 0.

Test Plan:
- BNE same page: OPCODE=0xD0, FLAGS=0000, PC_IN=0x1234, OFFSET=0x10 -> DONE 2 cycles after START, TAKEN=1, WR=1, LO=0x44, HI=0x12.
- BEQ not taken: OPCODE=0xF0, FLAGS Z=0, PC_IN=0x1234 -> DONE after 1 cycle, TAKEN=0, WR never asserted.
- Forward page cross: BCS 0xB0, C=1, PC_IN=0x12F0, OFFSET=0x20 -> 3 cycles, HI:LO=0x1310. Backward cross: PC_IN=0x1205, OFFSET=0xF0 -> 0x11F5.
- Address wrap: BMI 0x30, N=1, PC_IN=0xFFF0, OFFSET=0x20 -> 0x0010. Second case: PC_IN=0x0005, OFFSET=0x80 -> 0xFF85.
- Illegal opcode: OPCODE=0xA9 -> DONE after 1 cycle with ILLEGAL=1, TAKEN=0, WR=0. Also pulse START during BUSY with different operands -> ignored; first result unchanged.
- Reset mid-operation: R=1 in S_FIX -> next cycle BUSY=0, DONE=0, WR=0, LO=HI=0x00. A following START completes normally.
